// File: rtl/match_vector_decoder_if.sv
// ---------------------------------------------------------------------------
// match_vector_decoder_if
// Bundles the two streams around the match vector decoder.
//   Beat stream (upstream shift-or filter -> decoder):
//     in_data   match vector, bit 8*b+k = byte b, bucket k, 0 = match
//     in_valid  beat valid
//     in_last   beat is the last one of its packet
//     in_ready  decoder can take a beat (transfer = in_valid & in_ready)
//   Record stream (decoder -> rule/hash back end):
//     out_valid  record valid
//     out_ready  back end accepts the record
//     out_match  1 = match record, 0 = end-of-packet record
//     out_offset match: byte offset in packet; end-of-packet: match count
//     out_bucket match: bucket index; end-of-packet: 0
// Modports:
//   slave  - the decoder itself
//   master - the environment feeding beats and draining records
// ---------------------------------------------------------------------------
interface match_vector_decoder_if #(
  parameter int DATA_WIDTH   = 256,
  parameter int OFFSET_WIDTH = 16
);

  logic [DATA_WIDTH-1:0]   in_data;
  logic                    in_valid;
  logic                    in_last;
  logic                    in_ready;

  logic                    out_valid;
  logic                    out_ready;
  logic                    out_match;
  logic [OFFSET_WIDTH-1:0] out_offset;
  logic [2:0]              out_bucket;

  modport slave (
    input  in_data,
    input  in_valid,
    input  in_last,
    output in_ready,
    output out_valid,
    input  out_ready,
    output out_match,
    output out_offset,
    output out_bucket
  );

  modport master (
    output in_data,
    output in_valid,
    output in_last,
    input  in_ready,
    input  out_valid,
    output out_ready,
    input  out_match,
    input  out_offset,
    input  out_bucket
  );

endinterface

// File: rtl/match_vector_decoder.sv
// ---------------------------------------------------------------------------
// match_vector_decoder
// Reads the match vectors produced by the first-stage shift-or filter and
// turns them into a stream of records: one record per match (byte offset in
// the packet plus bucket index), followed by one end-of-packet record that
// carries the number of matches seen in that packet. Incoming beats are
// buffered in a small FIFO so the filter is not stalled by short bursts of
// back-pressure from the back end.
//
// Ports:
//   clk   clock
//   rst   asynchronous reset, active low (0 = reset)
//   bus   match_vector_decoder_if.slave
//         in_data/in_valid/in_last/in_ready   : beat stream in
//         out_valid/out_ready/out_match/
//         out_offset/out_bucket               : record stream out
//
// Notes:
//   - The FIFO stores the inverted vector, so a set bit means "match" and
//     the scanner works with an ordinary find-lowest-set-bit.
//   - Base offset and match count saturate at all-ones instead of wrapping.
// ---------------------------------------------------------------------------
module match_vector_decoder #(
  parameter int DATA_WIDTH   = 256,
  parameter int FIFO_DEPTH   = 4,
  parameter int OFFSET_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  match_vector_decoder_if.slave bus
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int OCC_W   = PTR_W + 1;
  localparam int ENTRY_W = DATA_WIDTH + 1;
  localparam int IDX_W   = $clog2(DATA_WIDTH);
  localparam int BYTES   = DATA_WIDTH / 8;

  localparam logic [OFFSET_WIDTH-1:0] OFFSET_MAX  = {OFFSET_WIDTH{1'b1}};
  localparam logic [OFFSET_WIDTH-1:0] OFFSET_ZERO = {OFFSET_WIDTH{1'b0}};
  localparam logic [OFFSET_WIDTH-1:0] OFFSET_ONE  = {{(OFFSET_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [OFFSET_WIDTH-1:0] BEAT_STRIDE = OFFSET_WIDTH'(BYTES);
  localparam logic [DATA_WIDTH-1:0]   VEC_ZERO    = {DATA_WIDTH{1'b0}};
  localparam logic [DATA_WIDTH-1:0]   VEC_ONE     = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [OCC_W-1:0]        OCC_ZERO    = {OCC_W{1'b0}};
  localparam logic [OCC_W-1:0]        OCC_ONE     = {{(OCC_W-1){1'b0}}, 1'b1};
  localparam logic [OCC_W-1:0]        OCC_FULL    = OCC_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0]        PTR_ZERO    = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0]        PTR_ONE     = {{(PTR_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_EOP  = 2'd2
  } state_t;

  // Index of the lowest set bit; returns 0 for an all-zero vector (callers
  // only use the result when the vector is non-zero).
  function automatic logic [IDX_W-1:0] lowest_set_idx(input logic [DATA_WIDTH-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = {IDX_W{1'b0}};
    for (int j = DATA_WIDTH - 1; j >= 0; j--) begin
      if (v[j]) begin
        idx = IDX_W'(j);
      end
    end
    return idx;
  endfunction

  // Unsigned add that clamps at all-ones instead of wrapping.
  function automatic logic [OFFSET_WIDTH-1:0] sat_add(input logic [OFFSET_WIDTH-1:0] a,
                                                      input logic [OFFSET_WIDTH-1:0] b);
    logic [OFFSET_WIDTH:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum[OFFSET_WIDTH]) begin
      return OFFSET_MAX;
    end else begin
      return sum[OFFSET_WIDTH-1:0];
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Beat FIFO
  // ---------------------------------------------------------------------------
  logic [ENTRY_W-1:0] fifo_mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [OCC_W-1:0]   occ_r;
  logic [OCC_W-1:0]   occ_nxt_s;
  logic               in_ready_r;
  logic               push_s;
  logic               pop_s;
  logic               fifo_empty_s;
  logic [ENTRY_W-1:0] fifo_head_s;

  assign push_s       = bus.in_valid & in_ready_r;
  assign fifo_empty_s = (occ_r == OCC_ZERO);
  assign fifo_head_s  = fifo_mem_r[rd_ptr_r];

  // Occupancy after this cycle's push/pop; a simultaneous push and pop cancel.
  always_comb begin
    occ_nxt_s = occ_r;
    case ({push_s, pop_s})
      2'b10:   occ_nxt_s = occ_r + OCC_ONE;
      2'b01:   occ_nxt_s = occ_r - OCC_ONE;
      default: occ_nxt_s = occ_r;
    endcase
  end

  // FIFO storage; the vector is inverted on the way in so 1 = match.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int e = 0; e < FIFO_DEPTH; e++) begin
        fifo_mem_r[e] <= {ENTRY_W{1'b0}};
      end
    end else if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= {bus.in_last, ~bus.in_data};
    end else begin
      fifo_mem_r[wr_ptr_r] <= fifo_mem_r[wr_ptr_r];
    end
  end

  // FIFO pointers, occupancy and the registered ready flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r   <= PTR_ZERO;
      rd_ptr_r   <= PTR_ZERO;
      occ_r      <= OCC_ZERO;
      in_ready_r <= 1'b0;
    end else begin
      wr_ptr_r   <= push_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
      rd_ptr_r   <= pop_s  ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
      occ_r      <= occ_nxt_s;
      in_ready_r <= (occ_nxt_s < OCC_FULL);
    end
  end

  // ---------------------------------------------------------------------------
  // Scanner
  // ---------------------------------------------------------------------------
  state_t                  state_r;
  state_t                  state_nxt_s;
  logic [DATA_WIDTH-1:0]   pend_r;
  logic                    pend_last_r;
  logic [OFFSET_WIDTH-1:0] base_r;
  logic [OFFSET_WIDTH-1:0] count_r;

  logic                    out_valid_r;
  logic                    out_match_r;
  logic [OFFSET_WIDTH-1:0] out_offset_r;
  logic [2:0]              out_bucket_r;

  logic                    slot_free_s;
  logic                    pend_any_s;
  logic [DATA_WIDTH-1:0]   pend_rest_s;
  logic [IDX_W-1:0]        pend_idx_s;
  logic [OFFSET_WIDTH-1:0] match_offset_s;
  logic                    emit_match_s;
  logic                    emit_eop_s;
  logic                    adv_base_s;

  assign slot_free_s = ~out_valid_r | bus.out_ready;
  assign pend_any_s  = (pend_r != VEC_ZERO);
  // x & (x-1) drops exactly the lowest set bit, i.e. the match being emitted.
  assign pend_rest_s = pend_r & (pend_r - VEC_ONE);
  assign pend_idx_s  = lowest_set_idx(pend_r);
  assign match_offset_s = sat_add(base_r, OFFSET_WIDTH'(pend_idx_s[IDX_W-1:3]));

  // Scanner state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Scanner next state and per-cycle actions.
  always_comb begin
    state_nxt_s  = state_r;
    pop_s        = 1'b0;
    emit_match_s = 1'b0;
    emit_eop_s   = 1'b0;
    adv_base_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!fifo_empty_s) begin
          pop_s       = 1'b1;
          state_nxt_s = ST_SCAN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (!slot_free_s) begin
          state_nxt_s = ST_SCAN;
        end else if (pend_any_s) begin
          emit_match_s = 1'b1;
          // Final match of a last beat: close the packet on the next cycle.
          if (pend_last_r && (pend_rest_s == VEC_ZERO)) begin
            state_nxt_s = ST_EOP;
          end else begin
            state_nxt_s = ST_SCAN;
          end
        end else if (!pend_last_r) begin
          // Beat exhausted mid-packet: step base and fetch the next beat now.
          adv_base_s  = 1'b1;
          pop_s       = ~fifo_empty_s;
          state_nxt_s = fifo_empty_s ? ST_IDLE : ST_SCAN;
        end else begin
          // Matchless last beat: close the packet without a detour via EOP.
          emit_eop_s  = 1'b1;
          pop_s       = ~fifo_empty_s;
          state_nxt_s = fifo_empty_s ? ST_IDLE : ST_SCAN;
        end
      end
      ST_EOP: begin
        if (slot_free_s) begin
          emit_eop_s  = 1'b1;
          pop_s       = ~fifo_empty_s;
          state_nxt_s = fifo_empty_s ? ST_IDLE : ST_SCAN;
        end else begin
          state_nxt_s = ST_EOP;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Pending match bits of the beat under scan.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_r      <= VEC_ZERO;
      pend_last_r <= 1'b0;
    end else if (pop_s) begin
      pend_r      <= fifo_head_s[DATA_WIDTH-1:0];
      pend_last_r <= fifo_head_s[DATA_WIDTH];
    end else if (emit_match_s) begin
      pend_r      <= pend_rest_s;
      pend_last_r <= pend_last_r;
    end else begin
      pend_r      <= pend_r;
      pend_last_r <= pend_last_r;
    end
  end

  // Packet-relative base offset and running match count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      base_r  <= OFFSET_ZERO;
      count_r <= OFFSET_ZERO;
    end else if (emit_eop_s) begin
      base_r  <= OFFSET_ZERO;
      count_r <= OFFSET_ZERO;
    end else begin
      base_r  <= adv_base_s   ? sat_add(base_r, BEAT_STRIDE) : base_r;
      count_r <= emit_match_s ? sat_add(count_r, OFFSET_ONE) : count_r;
    end
  end

  // Output record register: load, hold under back-pressure, or retire.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_r  <= 1'b0;
      out_match_r  <= 1'b0;
      out_offset_r <= OFFSET_ZERO;
      out_bucket_r <= 3'd0;
    end else if (emit_match_s) begin
      out_valid_r  <= 1'b1;
      out_match_r  <= 1'b1;
      out_offset_r <= match_offset_s;
      out_bucket_r <= pend_idx_s[2:0];
    end else if (emit_eop_s) begin
      out_valid_r  <= 1'b1;
      out_match_r  <= 1'b0;
      out_offset_r <= count_r;
      out_bucket_r <= 3'd0;
    end else if (bus.out_ready) begin
      out_valid_r  <= 1'b0;
      out_match_r  <= out_match_r;
      out_offset_r <= out_offset_r;
      out_bucket_r <= out_bucket_r;
    end else begin
      out_valid_r  <= out_valid_r;
      out_match_r  <= out_match_r;
      out_offset_r <= out_offset_r;
      out_bucket_r <= out_bucket_r;
    end
  end

  assign bus.in_ready   = in_ready_r;
  assign bus.out_valid  = out_valid_r;
  assign bus.out_match  = out_match_r;
  assign bus.out_offset = out_offset_r;
  assign bus.out_bucket = out_bucket_r;

endmodule
